pc_sequencer: RTL
=================

# pc_sequencer

Registered program-counter unit for the single-cycle core that replaces the combinational 4-bit-in/32-bit-out incrementer. It holds the PC, advances it by a parametrised step each cycle, and selects branch, jump, call and return targets. It also keeps a small circular return-address stack (RAS) and sticky error flags. It sits between the control/ALU stage, which supplies redirect requests, and the instruction-memory address port, which consumes `pc`.

## Interface
- `PC_WIDTH`, 32: width of the PC and every address port.
- `STEP`, 4: byte increment per sequential instruction.
- `ALIGN_BITS`, 2: number of low address bits that must be zero.
- `RESET_VECTOR`, 0: PC value after reset. Must be aligned.
- `RAS_DEPTH`, 4: return-stack entries. Power of two, ≥2.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hold every register this cycle.
- `branch_taken`  in  1  relative redirect.
- `branch_offset`  in  PC_WIDTH  signed byte offset, applied to pc+STEP.
- `jump`  in  1  absolute redirect to `jump_target`.
- `call`  in  1  absolute redirect to `jump_target` plus push of pc+STEP.
- `ret`  in  1  redirect to the top RAS entry, then pop.
- `jump_target`  in  PC_WIDTH  absolute target for jump/call.
- `pc`  out  PC_WIDTH  current PC (registered).
- `pc_next`  out  PC_WIDTH  value PC takes at the next unstalled edge (combinational).
- `ras_count`  out  $clog2(RAS_DEPTH)+1  valid RAS entries.
- `ras_empty`  out  1  `ras_count==0`.
- `ras_full`  out  1  `ras_count==RAS_DEPTH`.
- `misalign_err`  out  1  sticky flag: a misaligned target was seen.
- `ras_overflow`  out  1  sticky flag: a call was made while full.
- `ras_underflow`  out  1  sticky flag: a return was made while empty.

## Operation
- Define `seq = pc + STEP`. All arithmetic is modulo 2^PC_WIDTH, so wrap-around is silent and does not flag an error.
- Target priority, highest first:
  - ret: target is `ras[top]`.
  - call: target is `jump_target`.
  - jump: target is `jump_target`.
  - branch_taken: target is `seq + branch_offset`.
  - otherwise: `seq`.
- Alignment: the selected target has its low ALIGN_BITS forced to 0 before it drives `pc_next`.
  - If any forced bit was 1, `misalign_err` sets at the edge.
  - This check applies to the jump, call and branch targets. RAS contents are always aligned.
- Call while not full: write `seq` at `wr_ptr`, then `wr_ptr++` and `ras_count++`.
- Call while full: overwrite the oldest entry (circular), keep `ras_count` at RAS_DEPTH, and set `ras_overflow`.
- Ret while not empty: target is the entry at `wr_ptr-1`, then `wr_ptr--` and `ras_count--`.
- Ret while empty: target falls through to the next lower priority that is active, else `seq`. Set `ras_underflow`. Pointer and count stay unchanged.
- Ret and call asserted together: ret wins, and call is ignored (no push).
- `stall=1` freezes `pc`, the RAS, the pointers, the count and all flags. `pc_next` still shows the computed target.
- Sticky flags clear only on reset.

## Timing
- Reset is asynchronous. While `rst_n=0`:
  - `pc` = RESET_VECTOR.
  - `wr_ptr` = 0, `ras_count` = 0, so `ras_empty` = 1 and `ras_full` = 0.
  - All sticky flags = 0.
  - RAS entry contents are don't-care.
- Reset asserted mid-operation discards the stack immediately.
- The first edge after `rst_n` rises loads `pc_next`.
- Latency is one cycle: a redirect sampled at edge N appears on `pc` after edge N.
- A push or pop takes effect at the same edge, and `ras_count` reflects it in cycle N+1.
- A call immediately followed by a ret in the next cycle returns to the address pushed one cycle earlier (back-to-back).
- `pc_next` is purely combinational from `pc`, the RAS top and the inputs. It has no path from `rst_n` other than through registers.

## Test plan
- Reset sequencing: reset with RESET_VECTOR=0x100, then release and run 3 free cycles → `pc` = 0x100, 0x104, 0x108, 0x10C.
- Branch and wrap-around:
  - At pc=0x200, branch_taken with offset 0xFFFFFFF0 → pc=0x1F4.
  - At pc=0xFFFFFFFC, free-run → pc=0x0 with no flag set.
- Call/ret nesting, depth 4: call from 0x10 to 0x80, then call from 0x80 to 0x100, then ret, ret.
  - pc sequence: 0x80, 0x100, 0x84, 0x14.
  - ras_count sequence: 1, 2, 1, 0.
- Overflow and underflow:
  - Five calls with no returns → ras_full=1, ras_overflow=1, count=4. Four rets then return the last four pushes; the first push is lost.
  - A fifth ret → ras_underflow=1, pc=seq.
- Stall, priority and alignment:
  - Stall held for 3 cycles during a jump request → pc and count unchanged, pc_next = target.
  - ret+call+jump asserted together → ret target wins, no push.
  - Jump to 0x203 → pc=0x200, misalign_err=1.
  - Asynchronous reset asserted mid-cycle → misalign_err clears immediately.

Source files
------------

// File: rtl/pc_sequencer.sv
// Registered program counter with branch/jump/call/return target selection,
// a circular return-address stack and sticky error flags.
module pc_sequencer #(
  parameter int PC_WIDTH     = 32,
  parameter int STEP         = 4,
  parameter int ALIGN_BITS   = 2,
  parameter int RESET_VECTOR = 0,
  parameter int RAS_DEPTH    = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           stall,
  input  logic                           branch_taken,
  input  logic [PC_WIDTH-1:0]            branch_offset,
  input  logic                           jump,
  input  logic                           call,
  input  logic                           ret,
  input  logic [PC_WIDTH-1:0]            jump_target,
  output logic [PC_WIDTH-1:0]            pc,
  output logic [PC_WIDTH-1:0]            pc_next,
  output logic [$clog2(RAS_DEPTH):0]     ras_count,
  output logic                           ras_empty,
  output logic                           ras_full,
  output logic                           misalign_err,
  output logic                           ras_overflow,
  output logic                           ras_underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PC_WIDTH-1:0] STEP_V     = PC_WIDTH'(STEP);
  localparam logic [PC_WIDTH-1:0] RESET_V    = PC_WIDTH'(RESET_VECTOR);
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = {PC_WIDTH{1'b1}} << ALIGN_BITS;
  localparam logic [CNT_W-1:0]    DEPTH_V    = CNT_W'(RAS_DEPTH);

  logic [PC_WIDTH-1:0] pc_reg;
  logic [PC_WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_reg;
  logic [CNT_W-1:0]    ras_count_reg;
  logic                misalign_reg;
  logic                overflow_reg;
  logic                underflow_reg;

  logic [PC_WIDTH-1:0] seq_pc;
  logic [PC_WIDTH-1:0] ras_top;
  logic [PC_WIDTH-1:0] raw_target;
  logic                check_align;
  logic                misaligned;
  logic                do_pop;
  logic                do_push;

  assign seq_pc    = pc_reg + STEP_V;
  assign ras_top   = ras_mem[wr_ptr_reg - PTR_W'(1)];
  assign ras_empty = (ras_count_reg == '0);
  assign ras_full  = (ras_count_reg == DEPTH_V);

  // A ret on an empty stack does not pop; a ret always suppresses the push
  // of a simultaneous call, even when the target falls through to that call.
  assign do_pop  = ret && !ras_empty;
  assign do_push = call && !ret;

  // Target selection by priority; only externally supplied targets are checked
  // for alignment, since stack entries and the sequential PC are aligned.
  always_comb begin
    raw_target  = seq_pc;
    check_align = 1'b0;
    if (do_pop) begin
      raw_target = ras_top;
    end else if (call || jump) begin
      raw_target  = jump_target;
      check_align = 1'b1;
    end else if (branch_taken) begin
      raw_target  = seq_pc + branch_offset;
      check_align = 1'b1;
    end
  end

  assign misaligned = check_align && ((raw_target & ~ALIGN_MASK) != '0);
  assign pc_next    = raw_target & ALIGN_MASK;

  // PC, stack pointer, occupancy and sticky flags; all frozen by stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg        <= RESET_V;
      wr_ptr_reg    <= '0;
      ras_count_reg <= '0;
      misalign_reg  <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (!stall) begin
      pc_reg <= pc_next;
      if (misaligned) misalign_reg <= 1'b1;
      if (ret) begin
        if (do_pop) begin
          wr_ptr_reg    <= wr_ptr_reg - PTR_W'(1);
          ras_count_reg <= ras_count_reg - CNT_W'(1);
        end else begin
          underflow_reg <= 1'b1;
        end
      end else if (do_push) begin
        // When full, wr_ptr already points at the oldest entry, so the
        // push overwrites it and the count saturates.
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        if (ras_full) overflow_reg <= 1'b1;
        else          ras_count_reg <= ras_count_reg + CNT_W'(1);
      end
    end
  end

  // Stack storage; contents need no reset because the pointers discard them.
  always_ff @(posedge clk) begin
    if (!stall && do_push) ras_mem[wr_ptr_reg] <= seq_pc;
  end

  assign pc            = pc_reg;
  assign ras_count     = ras_count_reg;
  assign misalign_err  = misalign_reg;
  assign ras_overflow  = overflow_reg;
  assign ras_underflow = underflow_reg;

endmodule
